ps2_rx: RTL and testbench

Host-side receiver for the PS/2-style serial link driven by the keyboard/device model. Synchronises and de-glitches the open-collector `ps2_clk`/`ps2_dat` lines, samples data on each falling `ps2_clk` edge, and checks framing and odd parity. Delivers good bytes to the system through a valid/ready holding stage; framing, parity, timeout and overrun events are reported as one-cycle pulses.

---
 rtl/ps2_rx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 host receiver: synchronise and filter the lines, deserialise 11-bit frames, check framing
// and odd parity, then hand good bytes out through a holding register (a 4-entry FIFO with PS2_RX_FIFO_EN).
module ps2_rx #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Line conditioning: index 0 is ps2_clk, index 1 is ps2_dat.
  logic [1:0]    line_s;
  logic [1:0]    s1_q;
  logic [1:0]    s2_q;
  logic [1:0]    filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          fclk_prev_q;
  logic          fall;

  assign line_s = {ps2_dat, ps2_clk};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= 2'b11;
      s2_q        <= 2'b11;
      filt_q      <= 2'b11;
      fclk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      s1_q        <= line_s;
      s2_q        <= s1_q;
      fclk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER - 1)) begin
          filt_q[i] <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FW'(1);
        end
      end
    end
  end

  assign fall = fclk_prev_q & ~filt_q[0];

  // Frame FSM. Bits shift in from the top, so after 11 edges bit k sits at sr_q[k].
  state_e        state_q;
  logic [3:0]    bitcnt_q;
  logic [10:0]   sr_q;
  logic [WW-1:0] wd_q;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          timeout_err_q;
  logic          frame_bad;
  logic          par_bad;
  logic          good_frame;

  assign frame_bad  = sr_q[0] | ~sr_q[10];
  assign par_bad    = ~(^sr_q[9:1]);
  assign good_frame = (state_q == CHECK) & ~frame_bad & ~par_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bitcnt_q      <= 4'd0;
      sr_q          <= '0;
      wd_q          <= '0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (fall) begin
            sr_q     <= {filt_q[1], 10'b0};
            bitcnt_q <= 4'd1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            sr_q     <= {filt_q[1], sr_q[10:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            wd_q     <= '0;
            if (bitcnt_q == 4'd10) state_q <= CHECK;
          end else if (wd_q == WW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            bitcnt_q      <= 4'd0;
            wd_q          <= '0;
            state_q       <= IDLE;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        CHECK: begin
          bitcnt_q <= 4'd0;
          state_q  <= IDLE;
          if (frame_bad)    frame_err_q  <= 1'b1;
          else if (par_bad) parity_err_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake: a byte transfers on any cycle where rx_valid && rx_ready; rx_valid never drops
  // without a transfer, and a good frame may be loaded on the same cycle a transfer frees space.
  logic overrun_q;
  logic pop;
  logic push;
  logic overrun_d;

`ifdef PS2_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_q;
  logic [1:0] rd_q;
  logic [2:0] cnt_q;
  logic       full;

  always_comb begin
    full      = (cnt_q == 3'd4);
    pop       = (cnt_q != 3'd0) & rx_ready;
    push      = good_frame & (~full | pop);
    overrun_d = good_frame & full & ~pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
      wr_q      <= 2'd0;
      rd_q      <= 2'd0;
      cnt_q     <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      if (push) begin
        mem_q[wr_q] <= sr_q[8:1];
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end

  assign rx_data  = mem_q[rd_q];
  assign rx_valid = (cnt_q != 3'd0);
`else
  logic [7:0] data_q;
  logic [7:0] data_d;
  logic       valid_q;
  logic       valid_d;

  always_comb begin
    pop       = valid_q & rx_ready;
    push      = good_frame & (~valid_q | rx_ready);
    overrun_d = good_frame & valid_q & ~rx_ready;
    valid_d   = push | (valid_q & ~pop);
    data_d    = push ? sr_q[8:1] : data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
`endif

  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: frame-level reference model (classifies each frame and queues expected bytes),
// directed scenarios plus randomized frames.
`timescale 1ns/1ps
module tb_ps2_rx;
`ifdef PS2_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int TIMEOUT = 300;

  logic       clk;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       overrun;
  logic [1:0] dbg_state;

  ps2_rx #(.FILTER(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .timeout_err(timeout_err),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #500 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int exp_par = 0, exp_frm = 0, exp_to = 0, exp_ovr = 0;
  int obs_par = 0, obs_frm = 0, obs_to = 0, obs_ovr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pulses counted per high cycle, bytes compared at each handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (parity_err)  obs_par++;
      if (frame_err)   obs_frm++;
      if (timeout_err) obs_to++;
      if (overrun)     obs_ovr++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
        else                   check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Drivers: inputs change 1 ns after the rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] build(input logic [7:0] d, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^d, d, 1'b0};
    case (kind)
      1: f[9]  = ~f[9];
      2: f[10] = 1'b0;
      3: f[0]  = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int half, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      cycles(half);
      ps2_clk = 1'b0;
      cycles(half);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    cycles(half);
  endtask

  // Reference model: frame outcome from the framing/parity rules and current holding occupancy.
  task automatic model_frame(input logic [10:0] f);
    if (f[0] != 1'b0 || f[10] != 1'b1)            exp_frm++;
    else if ((^f[9:1]) != 1'b1)                   exp_par++;
    else if (rx_ready || exp_q.size() < DEPTH)    exp_q.push_back(f[8:1]);
    else                                          exp_ovr++;
  endtask

  task automatic send_byte(input logic [7:0] d, input int kind, input int half);
    logic [10:0] f;
    f = build(d, kind);
    model_frame(f);
    send_bits(f, half, 11);
    cycles(20);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_parity"},  obs_par, exp_par);
    check({tag, "_frame"},   obs_frm, exp_frm);
    check({tag, "_timeout"}, obs_to,  exp_to);
    check({tag, "_overrun"}, obs_ovr, exp_ovr);
    check({tag, "_state"},   {30'd0, dbg_state}, 32'd0);
    if (rx_ready) check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    rx_ready = 1'b1;
    cycles(3);
    check("rst_data",  {24'd0, rx_data}, 32'd0);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_pulses", {parity_err, frame_err, timeout_err, overrun}, 4'd0);
    reset_n = 1'b1;
    cycles(10);

    send_byte(8'hA5, 0, 40);
    check_counts("a5");
    send_byte(8'h3C, 1, 40);
    check_counts("parity");
    send_byte(8'h00, 2, 40);
    check_counts("stop");

    send_bits(build(8'h7E, 0), 20, 5);
    cycles(TIMEOUT + 100);
    exp_to++;
    check_counts("timeout");
    send_byte(8'h7E, 0, 20);
    check_counts("after_to");

    rx_ready = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) send_byte(8'(k * 17), 0, 16);
    check("held_data",  {24'd0, rx_data}, 32'h11);
    check("held_valid", rx_valid, 1'b1);
    check_counts("overrun");
    rx_ready = 1'b1;
    cycles(10);
    check_counts("drain");

    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      cycles(2);
      ps2_clk = 1'b1;
      cycles(10);
    end
    check_counts("glitch");
    send_byte(8'h5A, 0, 20);
    check_counts("after_glitch");

    send_bits(build(8'hF0, 0), 20, 7);
    reset_n = 1'b0;
    cycles(2);
    check("midrst_data",  {24'd0, rx_data}, 32'd0);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_pulses", {parity_err, frame_err, timeout_err, overrun}, 4'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete();
    reset_n = 1'b1;
    cycles(10);
    send_byte(8'hF0, 0, 20);
    check_counts("after_rst");

    for (int r = 0; r < 14; r++) begin
      int kind;
      kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      send_byte(8'($urandom), kind, int'($urandom_range(14, 40)));
    end
    check_counts("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
